booth_radix4_seq_mult: RTL and testbench
========================================

BOOTH_RADIX4_SEQ_MULT -- requirements
Module: booth_radix4_seq_mult

Interface
REQ-001 SHALL have parameter WIDTH_DATA, default 8, operand width; even and >= 4.
REQ-002 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_start  input  1  start request, sampled on i_clk rising edge.
REQ-005 SHALL have port i_multiplicand  input  WIDTH_DATA  signed two's-complement multiplicand M.
REQ-006 SHALL have port i_multiplier  input  WIDTH_DATA  signed two's-complement multiplier Q.
REQ-007 SHALL have port o_busy  output  1  high whenever state is not IDLE.
REQ-008 SHALL have port o_done  output  1  one-cycle pulse marking a new result on o_product.
REQ-009 SHALL have port o_product  output  2*WIDTH_DATA  signed product M*Q, registered.

Function
REQ-010 SHALL implement FSM states IDLE, CALC, DONE.
REQ-011 In IDLE with i_start=1: latch M and Q, clear accumulator and iteration counter, go to CALC.
REQ-012 In IDLE with i_start=0: remain in IDLE; no register changes.
REQ-013 i_start in CALC or DONE SHALL be ignored; operands not re-latched.
REQ-014 CALC SHALL run exactly WIDTH_DATA/2 cycles, one partial product per cycle, iteration i = 0..WIDTH_DATA/2-1.
REQ-015 Iteration i SHALL select triplet {Q[2i+1], Q[2i], Q[2i-1]}, with Q[-1] = 0.
REQ-016 Triplet decode SHALL be: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
REQ-017 Each partial product SHALL be sign-extended to 2*WIDTH_DATA bits, shifted left by 2i, added to the accumulator; additions are modulo 2^(2*WIDTH_DATA).
REQ-018 The -M and -2M terms SHALL be formed as two's-complement negation at a width of at least WIDTH_DATA+2 bits so M = -2^(WIDTH_DATA-1) negates correctly.
REQ-019 On the edge completing the last iteration: write final sum to o_product, go to DONE.
REQ-020 o_done SHALL be 1 exactly while in DONE (one cycle); DONE -> IDLE unconditionally on the next edge.
REQ-021 Latency: o_done and the new o_product appear on the WIDTH_DATA/2-th rising edge after the edge sampling i_start (4 edges for WIDTH_DATA=8).
REQ-022 o_product SHALL hold its last value until the next completion; it is not altered during CALC.
REQ-023 Back-to-back: i_start asserted in the cycle after o_done (state IDLE) SHALL be accepted; throughput is one product per WIDTH_DATA/2+2 cycles.
REQ-024 Result SHALL equal exact signed M*Q for all operand pairs, including -2^(WIDTH_DATA-1) * -2^(WIDTH_DATA-1).

Reset
REQ-025 i_rst=1 at a rising edge SHALL force state IDLE, o_busy=0, o_done=0, o_product=0, accumulator and counter = 0.
REQ-026 i_rst SHALL take priority over i_start and over any in-progress CALC/DONE; an aborted operation produces no o_done.
REQ-027 The first edge with i_rst=0 and i_start=1 SHALL start a new operation normally.

Verification (WIDTH_DATA=8)
REQ-028 M=0x0F (15), Q=0xF2 (-14), start -> o_done on 4th edge, o_product=0xFF2E (-210), o_busy high for 5 cycles.
REQ-029 M=0x80, Q=0x80 -> o_product=0x4000 (16384); M=0x7F, Q=0x80 -> o_product=0xC080 (-16256).
REQ-030 M=0x5A, Q=0x00 -> o_product=0x0000; then M=0xFF, Q=0xFF -> o_product=0x0001.
REQ-031 Start M=3, Q=5; pulse i_start with M=7, Q=7 during CALC -> o_product=15, single o_done pulse.
REQ-032 Start M=9, Q=9; assert i_rst at 2nd CALC edge -> o_product=0, o_busy=0, no o_done; next start M=2, Q=-3 -> 0xFFFA.
REQ-033 Random signed pairs (>=1000) back-to-back with i_start in the cycle after each o_done -> every result equals M*Q; o_done pulses are exactly one cycle.

Source files
------------

// File: rtl/booth_radix4_seq_mult.sv
// Sequential radix-4 Booth multiplier for signed two's-complement operands.
// Retires one Booth digit (two multiplier bits) per cycle, so a product takes
// WIDTH_DATA/2 cycles in CALC followed by one DONE cycle.
module booth_radix4_seq_mult #(
  parameter int unsigned WIDTH_DATA = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic [WIDTH_DATA-1:0]     i_multiplicand,
  input  logic [WIDTH_DATA-1:0]     i_multiplier,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [2*WIDTH_DATA-1:0]   o_product
);

  localparam int unsigned WidthProd = 2 * WIDTH_DATA;
  localparam int unsigned NumIter   = WIDTH_DATA / 2;
  localparam int unsigned WidthCnt  = $clog2(NumIter) + 1;
  localparam logic [WidthCnt-1:0] LastIter = WidthCnt'(NumIter - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic [WidthCnt-1:0]   cnt_q;
  logic [WidthProd-1:0]  acc_q;
  logic [WidthProd-1:0]  product_q;
  // Multiplicand, sign-extended and pre-shifted by 2i for the current iteration.
  logic [WidthProd-1:0]  mcand_q;
  // Multiplier with an appended Q[-1]=0; bits [2:0] are always the active triplet.
  logic [WIDTH_DATA:0]   mplier_q;

  logic [WidthProd-1:0]  pp;
  logic [WidthProd-1:0]  acc_sum;

  // Booth digit decode; negation at full product width so -(-2^(W-1)) is exact.
  always_comb begin
    pp = '0;
    unique case (mplier_q[2:0])
      3'b000, 3'b111: pp = '0;
      3'b001, 3'b010: pp = mcand_q;
      3'b011:         pp = mcand_q << 1;
      3'b100:         pp = -(mcand_q << 1);
      3'b101, 3'b110: pp = -mcand_q;
      default:        pp = '0;
    endcase
    acc_sum = acc_q + pp;
  end

  // Control FSM and datapath registers, synchronous active-high reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      product_q <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            mcand_q  <= {{WIDTH_DATA{i_multiplicand[WIDTH_DATA-1]}}, i_multiplicand};
            mplier_q <= {i_multiplier, 1'b0};
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= StCalc;
          end
        end
        StCalc: begin
          acc_q    <= acc_sum;
          mcand_q  <= mcand_q << 2;
          mplier_q <= mplier_q >> 2;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LastIter) begin
            product_q <= acc_sum;
            done_q    <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_product = product_q;

endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
// Directed and random checks for booth_radix4_seq_mult at WIDTH_DATA=8.
module tb_booth_radix4_seq_mult;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  mcand;
  logic [7:0]  mplier;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int n_vec = 0;
  int n_bad = 0;

  booth_radix4_seq_mult #(
    .WIDTH_DATA(8)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_multiplicand(mcand),
    .i_multiplier  (mplier),
    .o_busy        (busy),
    .o_done        (done),
    .o_product     (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for o_done, sampling 1 time unit after each rising edge.
  // Reports edges taken, busy samples seen and whether o_product moved early.
  task automatic wait_done(input logic [15:0] old_prod, output int cyc, output int nbusy,
                           output bit moved);
    cyc   = 0;
    nbusy = 1;
    moved = 0;
    while (!done && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy) nbusy++;
      if (!done && product !== old_prod) moved = 1;
    end
  endtask

  task automatic do_mult(input string tag, input logic [7:0] m, input logic [7:0] q,
                         input logic [15:0] exp);
    int cyc;
    int nbusy;
    bit moved;
    logic [15:0] old_prod;
    @(negedge clk);
    old_prod = product;
    mcand  = m;
    mplier = q;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, " busy_after_start"}, 32'(busy), 32'd1);
    wait_done(old_prod, cyc, nbusy, moved);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " latency"}, 32'(cyc), 32'd4);
    check({tag, " busy_cycles"}, 32'(nbusy), 32'd5);
    check({tag, " held_during_calc"}, 32'(moved), 32'd0);
    check({tag, " product"}, 32'(product), 32'(exp));
    @(posedge clk);
    #1;
    check({tag, " done_one_cycle"}, 32'(done), 32'd0);
    check({tag, " idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cyc;
    int nbusy;
    bit moved;
    int extra;
    logic [7:0] m;
    logic [7:0] q;
    logic signed [15:0] ms;
    logic signed [15:0] qs;

    rst    = 1'b1;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset product", 32'(product), 32'd0);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    start = 1'b1;
    mcand = 8'h11;
    mplier = 8'h11;
    @(posedge clk);
    #1;
    check("reset_prio busy", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;

    do_mult("m15xm14", 8'h0F, 8'hF2, 16'hFF2E);
    do_mult("min_x_min", 8'h80, 8'h80, 16'h4000);
    do_mult("max_x_min", 8'h7F, 8'h80, 16'hC080);
    do_mult("x_zero", 8'h5A, 8'h00, 16'h0000);
    do_mult("neg1_x_neg1", 8'hFF, 8'hFF, 16'h0001);

    // Start during CALC must be ignored.
    @(negedge clk);
    mcand = 8'd3;
    mplier = 8'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    mcand = 8'd7;
    mplier = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(16'h0001, cyc, nbusy, moved);
    check("ignore_start done", 32'(done), 32'd1);
    check("ignore_start latency", 32'(cyc), 32'd3);
    check("ignore_start product", 32'(product), 32'd15);
    extra = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    check("ignore_start single_done", 32'(extra), 32'd0);

    // Reset aborts an operation at its second CALC edge.
    @(negedge clk);
    mcand = 8'd9;
    mplier = 8'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort product", 32'(product), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done || busy) extra++;
    end
    check("abort quiet", 32'(extra), 32'd0);
    do_mult("after_abort", 8'd2, 8'hFD, 16'hFFFA);

    // Random back-to-back operation.
    for (int i = 0; i < 1000; i++) begin
      m  = 8'($urandom);
      q  = 8'($urandom);
      ms = $signed(m);
      qs = $signed(q);
      do_mult("random", m, q, 16'(ms * qs));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
